// File: rtl/wfg_subcore_timer.sv
// Subcycle/sync strobe generator for the waveform generator subcore.
// Configuration is shadowed and only reloaded when a sync period wraps.
module wfg_subcore_timer #(
    parameter int unsigned SUBW  = 16,
    parameter int unsigned SYNCW = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ctrl_en_q_i,
    input  logic [SUBW-1:0]  cfg_subcycle_q_i,
    input  logic [SYNCW-1:0] cfg_sync_q_i,
    output logic             wfg_subcycle_o,
    output logic             wfg_sync_o,
    output logic [SYNCW-1:0] wfg_sync_cnt_o,
    output logic             wfg_active_o
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           state_q;
    logic [SUBW-1:0]  sub_cnt_q;
    logic [SUBW-1:0]  sub_q;
    logic [SYNCW-1:0] sync_cnt_q;
    logic [SYNCW-1:0] sync_q;
    logic             subcycle_q;
    logic             sync_strobe_q;
    logic             active_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= StIdle;
            sub_cnt_q     <= '0;
            sub_q         <= '0;
            sync_cnt_q    <= '0;
            sync_q        <= '0;
            subcycle_q    <= 1'b0;
            sync_strobe_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ctrl_en_q_i) begin
                        state_q       <= StRun;
                        sub_q         <= cfg_subcycle_q_i;
                        sync_q        <= cfg_sync_q_i;
                        sub_cnt_q     <= '0;
                        sync_cnt_q    <= '0;
                        subcycle_q    <= 1'b1;
                        sync_strobe_q <= 1'b1;
                        active_q      <= 1'b1;
                    end
                end
                StRun: begin
                    if (!ctrl_en_q_i) begin
                        // Abort without finishing the period; next enable restarts phase 0.
                        state_q       <= StIdle;
                        sub_cnt_q     <= '0;
                        sync_cnt_q    <= '0;
                        subcycle_q    <= 1'b0;
                        sync_strobe_q <= 1'b0;
                        active_q      <= 1'b0;
                    end else if (sub_cnt_q == sub_q) begin
                        sub_cnt_q  <= '0;
                        subcycle_q <= 1'b1;
                        if (sync_cnt_q == sync_q) begin
                            sync_cnt_q    <= '0;
                            sync_strobe_q <= 1'b1;
                            sub_q         <= cfg_subcycle_q_i;
                            sync_q        <= cfg_sync_q_i;
                        end else begin
                            sync_cnt_q    <= sync_cnt_q + SYNCW'(1);
                            sync_strobe_q <= 1'b0;
                        end
                    end else begin
                        sub_cnt_q     <= sub_cnt_q + SUBW'(1);
                        subcycle_q    <= 1'b0;
                        sync_strobe_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wfg_subcycle_o = subcycle_q;
    assign wfg_sync_o     = sync_strobe_q;
    assign wfg_sync_cnt_o = sync_cnt_q;
    assign wfg_active_o   = active_q;

endmodule

// File: tb/tb_wfg_subcore_timer.sv
// Directed bench for wfg_subcore_timer: pacing, degenerate and maximum settings,
// reconfiguration, disable/re-enable and reset.
module tb_wfg_subcore_timer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] cfg_sub;
    logic [7:0]  cfg_sync;
    logic        sub_o;
    logic        sync_o;
    logic [7:0]  cnt_o;
    logic        act_o;

    // Narrow instance so a full sync wrap at maximum settings is cheap to reach.
    logic        en_s;
    logic [3:0]  cfg_sub_s;
    logic [2:0]  cfg_sync_s;
    logic        sub_s;
    logic        sync_s;
    logic [2:0]  cnt_s;
    logic        act_s;

    int checks = 0;
    int errors = 0;

    wfg_subcore_timer dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .ctrl_en_q_i     (en),
        .cfg_subcycle_q_i(cfg_sub),
        .cfg_sync_q_i    (cfg_sync),
        .wfg_subcycle_o  (sub_o),
        .wfg_sync_o      (sync_o),
        .wfg_sync_cnt_o  (cnt_o),
        .wfg_active_o    (act_o)
    );

    wfg_subcore_timer #(
        .SUBW (4),
        .SYNCW(3)
    ) dut_small (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .ctrl_en_q_i     (en_s),
        .cfg_subcycle_q_i(cfg_sub_s),
        .cfg_sync_q_i    (cfg_sync_s),
        .wfg_subcycle_o  (sub_s),
        .wfg_sync_o      (sync_s),
        .wfg_sync_cnt_o  (cnt_s),
        .wfg_active_o    (act_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After this returns we are in "cycle k", the window following edge k.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en = 1'b0;
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== 11'h0) begin
            errors++;
            $display("FAIL go_idle: got act/sub/sync/cnt=%b/%b/%b/%0d required 0/0/0/0",
                     act_o, sub_o, sync_o, cnt_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en_s = 1'b0;
        cfg_sub = 16'd3; cfg_sync = 8'd1; cfg_sub_s = 4'd0; cfg_sync_s = 3'd0;
        tick();
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== 11'h0) begin
            errors++;
            $display("FAIL reset: got act/sub/sync/cnt=%b/%b/%b/%0d required 0/0/0/0",
                     act_o, sub_o, sync_o, cnt_o);
        end
        checks++;
        if ({act_s, sub_s, sync_s, cnt_s} !== 6'h0) begin
            errors++;
            $display("FAIL reset_small: got %b required 000000", {act_s, sub_s, sync_s, cnt_s});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({act_o, sub_o, sync_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold: got %b required 000", {act_o, sub_o, sync_o});
        end
    endtask

    task automatic test_basic();
        logic [10:0] exp;
        cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp = {1'b1, (c % 4) == 0, (c % 8) == 0, 8'((c / 4) % 2)};
            checks++;
            if ({act_o, sub_o, sync_o, cnt_o} !== exp) begin
                errors++;
                $display("FAIL basic c%0d: got %b required %b", c,
                         {act_o, sub_o, sync_o, cnt_o}, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_degenerate();
        logic [10:0] exp;
        cfg_sub = 16'd0; cfg_sync = 8'd0; en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({act_o, sub_o, sync_o, cnt_o} !== {3'b111, 8'd0}) begin
                errors++;
                $display("FAIL degen00 c%0d: got %b required 11100000000", c,
                         {act_o, sub_o, sync_o, cnt_o});
            end
        end
        go_idle();
        cfg_sub = 16'd0; cfg_sync = 8'd2; en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            exp = {2'b11, (c % 3) == 0, 8'(c % 3)};
            checks++;
            if ({act_o, sub_o, sync_o, cnt_o} !== exp) begin
                errors++;
                $display("FAIL degen02 c%0d: got %b required %b", c,
                         {act_o, sub_o, sync_o, cnt_o}, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_reconfig();
        logic [10:0] exp;
        int d;
        cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c < 8) begin
                exp = {1'b1, (c % 4) == 0, c == 0, 8'(c / 4)};
            end else begin
                d = c - 8;
                exp = {1'b1, (d % 2) == 0, (d % 4) == 0, 8'((d / 2) % 2)};
            end
            checks++;
            if ({act_o, sub_o, sync_o, cnt_o} !== exp) begin
                errors++;
                $display("FAIL reconfig c%0d: got %b required %b", c,
                         {act_o, sub_o, sync_o, cnt_o}, exp);
            end
            if (c == 3) cfg_sub = 16'd1;
        end
        go_idle();
    endtask

    task automatic test_disable();
        logic [10:0] exp;
        int d;
        cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c < 6) begin
                exp = {1'b1, (c % 4) == 0, c == 0, 8'(c / 4)};
            end else if (c < 11) begin
                exp = 11'h0;
            end else begin
                d = c - 11;
                exp = {1'b1, (d % 4) == 0, (d % 8) == 0, 8'((d / 4) % 2)};
            end
            checks++;
            if ({act_o, sub_o, sync_o, cnt_o} !== exp) begin
                errors++;
                $display("FAIL disable c%0d: got %b required %b", c,
                         {act_o, sub_o, sync_o, cnt_o}, exp);
            end
            if (c == 5) en = 1'b0;
            if (c == 10) en = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== {3'b100, 8'd1}) begin
            errors++;
            $display("FAIL rst_pre: got %b required 10000000001", {act_o, sub_o, sync_o, cnt_o});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== 11'h0) begin
            errors++;
            $display("FAIL rst_mid: got %b required 0", {act_o, sub_o, sync_o, cnt_o});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== {3'b111, 8'd0}) begin
            errors++;
            $display("FAIL rst_restart: got %b required 11100000000",
                     {act_o, sub_o, sync_o, cnt_o});
        end
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== {3'b100, 8'd0}) begin
            errors++;
            $display("FAIL rst_after: got %b required 10000000000",
                     {act_o, sub_o, sync_o, cnt_o});
        end
        go_idle();
    endtask

    task automatic test_max();
        int bad;
        logic [5:0] exp_s;
        cfg_sub = 16'hFFFF; cfg_sync = 8'hFF; en = 1'b1;
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== {3'b111, 8'd0}) begin
            errors++;
            $display("FAIL max_start: got %b required 11100000000", {act_o, sub_o, sync_o, cnt_o});
        end
        bad = 0;
        for (int c = 1; c < 65536; c++) begin
            tick();
            if (sub_o !== 1'b0 || sync_o !== 1'b0 || act_o !== 1'b1 || cnt_o !== 8'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_quiet: got %0d bad cycles required 0", bad);
        end
        tick();
        checks++;
        if ({act_o, sub_o, sync_o, cnt_o} !== {3'b110, 8'd1}) begin
            errors++;
            $display("FAIL max_sub_wrap: got %b required 11000000001",
                     {act_o, sub_o, sync_o, cnt_o});
        end
        go_idle();

        cfg_sub_s = 4'hF; cfg_sync_s = 3'h7; en_s = 1'b1;
        for (int c = 0; c < 260; c++) begin
            tick();
            exp_s = {2'b11, (c % 16) == 0, (c % 128) == 0, 3'((c / 16) % 8)} >> 1;
            exp_s = {1'b1, (c % 16) == 0, (c % 128) == 0, 3'((c / 16) % 8)};
            checks++;
            if ({act_s, sub_s, sync_s, cnt_s} !== exp_s) begin
                errors++;
                $display("FAIL max_small c%0d: got %b required %b", c,
                         {act_s, sub_s, sync_s, cnt_s}, exp_s);
            end
        end
        en_s = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_degenerate();
        test_reconfig();
        test_disable();
        test_reset_mid();
        test_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
